// File: rtl/uart_tx_controller.sv
// UART transmitter: start bit, DATA_WIDTH data bits (LSB first), optional parity bit, stop bit.
// Latency: TX_OUT falls on the accepting edge; each bit lasts until the next BIT_TICK.
// Backpressure: busy is high for the whole frame; Data_valid outside IDLE is dropped.
module uart_tx_controller #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  BIT_TICK,
   output logic                  TX_OUT,
   output logic                  busy
);

   localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

   logic [2:0]            state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  par_en_q, par_en_d;
   logic                  par_typ_q, par_typ_d;
   logic                  tx_d, busy_d;

   // Next-state, bit index and holding-register update
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      data_d    = data_q;
      par_en_d  = par_en_q;
      par_typ_d = par_typ_q;
      case (state_q)
         IDLE: begin
            // BIT_TICK is deliberately not looked at here
            if (Data_valid) begin
               state_d   = START;
               idx_d     = '0;
               data_d    = P_DATA;
               par_en_d  = PAR_EN;
               par_typ_d = PAR_TYP;
            end
         end
         START: begin
            if (BIT_TICK) begin
               state_d = DATA;
               idx_d   = '0;
            end
         end
         DATA: begin
            if (BIT_TICK) begin
               if (idx_q == LAST_IDX) begin
                  state_d = par_en_q ? PARITY : STOP;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         PARITY: begin
            if (BIT_TICK) begin
               state_d = STOP;
            end
         end
         STOP: begin
            if (BIT_TICK) begin
               state_d = IDLE;
            end
         end
         default: begin
            // Unused encodings recover to IDLE
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // Line level and busy derived from the state being entered, so they register with it
   always_comb begin
      tx_d   = 1'b1;
      busy_d = (state_d != IDLE);
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = data_d[idx_d];
         PARITY:  tx_d = (^data_d) ^ par_typ_d;
         default: tx_d = 1'b1;
      endcase
   end

   // State, holding registers and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         data_q    <= '0;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
         TX_OUT    <= 1'b1;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         data_q    <= data_d;
         par_en_q  <= par_en_d;
         par_typ_q <= par_typ_d;
         TX_OUT    <= tx_d;
         busy      <= busy_d;
      end
   end

endmodule
